// File: rtl/voxel_wb_pkg.sv
// Shared types and constants for the voxel pixel writeback stage.
// Contents:
//   wb_entry_t       - one FIFO entry: pixel/end-of-frame flags, pixel index, 96-bit payload
//   BYTES_PER_PIXEL  - framebuffer footprint of one pixel
//   BEATS_PER_PIXEL  - 32-bit memory beats per pixel
//   wb_state_t       - writeback FSM states
package voxel_wb_pkg;

    localparam int unsigned BYTES_PER_PIXEL = 12;
    localparam int unsigned BEATS_PER_PIXEL = 3;

    typedef struct packed {
        logic        pix;
        logic        eof;
        logic [31:0] addr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
    } wb_entry_t;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } wb_state_t;

endpackage

// File: rtl/voxel_wb_fifo.sv
// Synchronous FIFO of wb_entry_t with registered storage and occupancy output.
// Ports:
//   clk_i, rst_i    - clock, synchronous active-high reset (discards contents)
//   push_i, wdata_i - write request and entry; ignored when full
//   pop_i           - read request; ignored when empty
//   rdata_o         - head entry (valid while level_o != 0)
//   level_o         - number of stored entries, 0..Depth
// Simultaneous push and pop leaves the level unchanged.
module voxel_wb_fifo
    import voxel_wb_pkg::*;
#(
    parameter int unsigned Depth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  wb_entry_t              wdata_i,
    input  logic                   pop_i,
    output wb_entry_t              rdata_o,
    output logic [$clog2(Depth):0] level_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FullLvl = LW'(Depth);

    wb_entry_t     mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push  = push_i && (level_q != FullLvl);
        do_pop   = pop_i && (level_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/voxel_pixel_writeback.sv
// Writeback stage of the voxel framebuffer: queues 96-bit pixel writes and
// end-of-frame markers, serialises each pixel into three 32-bit beats on a
// valid/ready memory port targeting the back buffer, and flips front/back
// buffers once every pixel of a finished frame has been accepted.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   pixel_write_en, pixel_addr,
//   pixel_word0..2               - pixel write (no backpressure)
//   frame_done_in                - one-cycle end-of-frame pulse
//   mem_valid/ready/addr/data/last - beat output; mem_last marks beat 2
//   front_buf_sel, frame_swap    - displayed buffer and one-cycle flip pulse
//   overflow, drop_count         - sticky drop flag, saturating drop counter
//   fifo_level, wb_busy          - FIFO occupancy and activity status
module voxel_pixel_writeback
    import voxel_wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] FB_BASE0   = 32'h0000_0000,
    parameter logic [31:0] FB_BASE1   = 32'h0010_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pixel_write_en,
    input  logic [31:0]                 pixel_addr,
    input  logic [31:0]                 pixel_word0,
    input  logic [31:0]                 pixel_word1,
    input  logic [31:0]                 pixel_word2,
    input  logic                        frame_done_in,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_data,
    output logic                        mem_last,
    output logic                        front_buf_sel,
    output logic                        frame_swap,
    output logic                        overflow,
    output logic [15:0]                 drop_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        wb_busy
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    // The top slot is kept for markers so a full FIFO can still end a frame.
    localparam logic [LW-1:0] PixLimit  = LW'(FIFO_DEPTH - 1);
    localparam logic [LW-1:0] MarkLimit = LW'(FIFO_DEPTH);
    localparam logic [1:0]    LastBeat  = 2'(BEATS_PER_PIXEL - 1);
    localparam logic [31:0]   BeatStep  = 32'(BYTES_PER_PIXEL / BEATS_PER_PIXEL);

    // Input admission
    wb_entry_t   push_entry;
    logic        push_req;
    logic        push_ok;
    logic        push_drop;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_q, drop_d;

    // FIFO read side
    wb_entry_t   head;
    logic        head_valid;
    logic        pop;

    // FSM and beat register
    wb_state_t   state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic        cur_eof_q, cur_eof_d;
    logic [31:0] w1_q, w1_d;
    logic [31:0] w2_q, w2_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        mem_last_q, mem_last_d;
    logic        front_q, front_d;
    logic        swap_q, swap_d;
    logic [31:0] head_beat0_addr;

    always_comb begin
        push_entry.pix  = pixel_write_en;
        push_entry.eof  = frame_done_in;
        push_entry.addr = pixel_addr;
        push_entry.w0   = pixel_word0;
        push_entry.w1   = pixel_word1;
        push_entry.w2   = pixel_word2;
        push_req        = pixel_write_en || frame_done_in;
        push_ok         = push_req &&
                          (pixel_write_en ? (fifo_level < PixLimit) : (fifo_level < MarkLimit));
        push_drop       = push_req && !push_ok;
        overflow_d      = overflow_q || push_drop;
        drop_d          = (push_drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    end

    voxel_wb_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_ok),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .level_o (fifo_level)
    );

    assign head_valid = (fifo_level != '0);

    // Writes go to the back buffer; index*12 formed as shift-and-add, wrapping mod 2^32.
    assign head_beat0_addr = (front_q ? FB_BASE0 : FB_BASE1) +
                             (head.addr << 3) + (head.addr << 2);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cur_eof_d   = cur_eof_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_last_d  = mem_last_q;
        front_d     = front_q;
        swap_d      = 1'b0;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (head_valid) begin
                    pop = 1'b1;
                    if (head.pix) begin
                        state_d     = StSend;
                        beat_d      = 2'd0;
                        cur_eof_d   = head.eof;
                        w1_d        = head.w1;
                        w2_d        = head.w2;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = head_beat0_addr;
                        mem_data_d  = head.w0;
                        mem_last_d  = 1'b0;
                    end else begin
                        front_d = ~front_q;
                        swap_d  = 1'b1;
                    end
                end
            end
            StSend: begin
                if (mem_ready) begin
                    if (beat_q != LastBeat) begin
                        beat_d     = beat_q + 2'd1;
                        mem_addr_d = mem_addr_q + BeatStep;
                        mem_data_d = (beat_q == 2'd0) ? w1_q : w2_q;
                        mem_last_d = (beat_q + 2'd1 == LastBeat);
                    end else if (cur_eof_q) begin
                        front_d     = ~front_q;
                        swap_d      = 1'b1;
                        state_d     = StIdle;
                        mem_valid_d = 1'b0;
                        mem_last_d  = 1'b0;
                    end else if (head_valid && head.pix) begin
                        // Back-to-back: next pixel's beat 0 follows immediately.
                        pop         = 1'b1;
                        beat_d      = 2'd0;
                        cur_eof_d   = head.eof;
                        w1_d        = head.w1;
                        w2_d        = head.w2;
                        mem_addr_d  = head_beat0_addr;
                        mem_data_d  = head.w0;
                        mem_last_d  = 1'b0;
                    end else begin
                        state_d     = StIdle;
                        mem_valid_d = 1'b0;
                        mem_last_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= 2'd0;
            cur_eof_q   <= 1'b0;
            w1_q        <= '0;
            w2_q        <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_last_q  <= 1'b0;
            front_q     <= 1'b0;
            swap_q      <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cur_eof_q   <= cur_eof_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_last_q  <= mem_last_d;
            front_q     <= front_d;
            swap_q      <= swap_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
        end
    end

    assign mem_valid     = mem_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign mem_last      = mem_last_q;
    assign front_buf_sel = front_q;
    assign frame_swap    = swap_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_q;
    assign wb_busy       = head_valid || (state_q != StIdle);

endmodule

// File: tb/tb_voxel_pixel_writeback.sv
// Self-checking bench for voxel_pixel_writeback: reset values, a table of
// single-pixel address/latency vectors, directed multi-cycle sequences
// (stalls, frame flip, combined pixel+eof, overflow, reset mid-beat) and a
// randomized run checked against a transaction-level beat/swap model.
module tb_voxel_pixel_writeback;

    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B1 = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_write_en = 1'b0;
    logic [31:0] pixel_addr = '0;
    logic [31:0] pixel_word0 = '0;
    logic [31:0] pixel_word1 = '0;
    logic [31:0] pixel_word2 = '0;
    logic        frame_done_in = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_last;
    logic        front_buf_sel;
    logic        frame_swap;
    logic        overflow;
    logic [15:0] drop_count;
    logic [4:0]  fifo_level;
    logic        wb_busy;

    always #5 clk = ~clk;

    voxel_pixel_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_write_en (pixel_write_en),
        .pixel_addr     (pixel_addr),
        .pixel_word0    (pixel_word0),
        .pixel_word1    (pixel_word1),
        .pixel_word2    (pixel_word2),
        .frame_done_in  (frame_done_in),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_last       (mem_last),
        .front_buf_sel  (front_buf_sel),
        .frame_swap     (frame_swap),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .fifo_level     (fifo_level),
        .wb_busy        (wb_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic en, input logic fd, input logic [31:0] a,
                        input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        pixel_write_en = en;
        frame_done_in  = fd;
        pixel_addr     = a;
        pixel_word0    = w0;
        pixel_word1    = w1;
        pixel_word2    = w2;
        step();
        pixel_write_en = 1'b0;
        frame_done_in  = 1'b0;
    endtask

    // Expected and collected beat streams for the directed sequences
    logic [31:0] e_addr[$], e_data[$];
    logic        e_last[$];
    logic [31:0] g_addr[$], g_data[$];
    logic        g_last[$];
    int          swaps;
    int          swap_at;

    task automatic exp_pixel(input logic [31:0] base, input logic [31:0] a,
                             input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] off;
        off = a * 32'd12;
        e_addr.push_back(base + off);        e_data.push_back(w0); e_last.push_back(1'b0);
        e_addr.push_back(base + off + 32'd4); e_data.push_back(w1); e_last.push_back(1'b0);
        e_addr.push_back(base + off + 32'd8); e_data.push_back(w2); e_last.push_back(1'b1);
    endtask

    // Drive mem_ready (0: always 1, 1: alternate 1/0, 2: random) for a fixed
    // number of cycles, recording accepted beats and checking stall stability.
    task automatic collect(input int mode, input int cycles);
        logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [31:0] pa = '0, pd = '0;
        g_addr.delete(); g_data.delete(); g_last.delete();
        swaps = 0;
        swap_at = -1;
        for (int c = 0; c < cycles; c++) begin
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = (c % 2 == 0);
                default: mem_ready = ($urandom_range(0, 1) == 1);
            endcase
            @(negedge clk);
            if (pv && !pr) begin
                chk("hold_valid", mem_valid, 1);
                chk("hold_addr", mem_addr, pa);
                chk("hold_data", mem_data, pd);
                chk("hold_last", mem_last, pl);
            end
            if (mem_valid && mem_ready) begin
                g_addr.push_back(mem_addr);
                g_data.push_back(mem_data);
                g_last.push_back(mem_last);
            end
            if (frame_swap) begin
                swaps++;
                swap_at = g_addr.size();
            end
            pv = mem_valid; pr = mem_ready; pa = mem_addr; pd = mem_data; pl = mem_last;
            step();
        end
        mem_ready = 1'b0;
    endtask

    task automatic compare_beats(input string tag);
        int n;
        chk({tag, "_beat_count"}, g_addr.size(), e_addr.size());
        n = (g_addr.size() < e_addr.size()) ? g_addr.size() : e_addr.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, g_addr[i], e_addr[i]);
            chk({tag, "_data"}, g_data[i], e_data[i]);
            chk({tag, "_last"}, g_last[i], e_last[i]);
        end
        e_addr.delete(); e_data.delete(); e_last.delete();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] ea;  // expected beat-0 address (front buffer 0 -> base FB_BASE1)
    } vec_t;

    typedef struct {
        bit          sw;
        logic [31:0] a;
        logic [31:0] d;
        logic        l;
        logic        f;
    } ev_t;

    initial begin
        vec_t        vecs[5];
        ev_t         evq[$];
        ev_t         ev;
        logic        m_front;
        logic [31:0] ra, r0, r1, r2, roff;
        logic        pv, pr, pl;
        logic [31:0] pa, pd;
        int          kind;

        vecs[0] = '{32'd5,          32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'h0010_003C};
        vecs[1] = '{32'd0,          32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0010_0000};
        vecs[2] = '{32'h1555_5556,  32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_F00D, 32'h0010_0008};
        vecs[3] = '{32'hFFFF_FFFF,  32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h000F_FFF4};
        vecs[4] = '{32'h0000_0100,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h0010_0C00};

        // Reset values
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_last", mem_last, 0);
        chk("rst_front", front_buf_sel, 0);
        chk("rst_swap", frame_swap, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", wb_busy, 0);
        step();

        // Single-pixel vectors: latency, addresses (incl. wrap), data order, last flag
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 1'b0, vecs[i].a, vecs[i].w0, vecs[i].w1, vecs[i].w2);
            @(negedge clk);
            chk("tbl_lat_n1_valid", mem_valid, 0);
            for (int k = 0; k < 3; k++) begin
                step();
                @(negedge clk);
                chk("tbl_valid", mem_valid, 1);
                chk("tbl_addr", mem_addr, vecs[i].ea + 32'(4 * k));
                chk("tbl_data", mem_data,
                    (k == 0) ? vecs[i].w0 : ((k == 1) ? vecs[i].w1 : vecs[i].w2));
                chk("tbl_last", mem_last, (k == 2) ? 1 : 0);
                chk("tbl_busy", wb_busy, 1);
            end
            step();
            @(negedge clk);
            chk("tbl_post_valid", mem_valid, 0);
            chk("tbl_swap", frame_swap, 0);
            chk("tbl_front", front_buf_sel, 0);
            step();
        end
        mem_ready = 1'b0;

        // Four pixels then a standalone frame_done, ready alternating
        for (int i = 0; i < 4; i++) begin
            r0 = $urandom(); r1 = $urandom(); r2 = $urandom();
            push(1'b1, 1'b0, 32'(10 + i), r0, r1, r2);
            exp_pixel(B1, 32'(10 + i), r0, r1, r2);
        end
        push(1'b0, 1'b1, '0, '0, '0, '0);
        collect(1, 60);
        compare_beats("seq4");
        chk("seq4_swaps", swaps, 1);
        chk("seq4_swap_at", swap_at, 12);
        chk("seq4_front", front_buf_sel, 1);
        push(1'b1, 1'b0, 32'd7, 32'h7777_0000, 32'h7777_0001, 32'h7777_0002);
        exp_pixel(B0, 32'd7, 32'h7777_0000, 32'h7777_0001, 32'h7777_0002);
        collect(0, 10);
        compare_beats("next_b0");
        chk("next_b0_swaps", swaps, 0);

        // Pixel and frame_done in the same cycle: one entry, swap after its last beat
        push(1'b1, 1'b1, 32'd3, 32'h3333_000A, 32'h3333_000B, 32'h3333_000C);
        @(negedge clk);
        chk("combo_level", fifo_level, 1);
        step();
        exp_pixel(B0, 32'd3, 32'h3333_000A, 32'h3333_000B, 32'h3333_000C);
        collect(0, 10);
        compare_beats("combo");
        chk("combo_swaps", swaps, 1);
        chk("combo_swap_at", swap_at, 3);
        chk("combo_front", front_buf_sel, 0);

        // Overflow: 20 pixels with memory stalled. One drains into the beat
        // register, 15 fill the pixel slots, 4 are dropped.
        for (int i = 0; i < 20; i++) begin
            push(1'b1, 1'b0, 32'(i), 32'(32'hA000_0000 + i), 32'(32'hB000_0000 + i),
                 32'(32'hC000_0000 + i));
            if (i < 16) begin
                exp_pixel(B1, 32'(i), 32'(32'hA000_0000 + i), 32'(32'hB000_0000 + i),
                          32'(32'hC000_0000 + i));
            end
        end
        @(negedge clk);
        chk("ovf_level", fifo_level, 15);
        chk("ovf_drop", drop_count, 4);
        chk("ovf_flag", overflow, 1);
        step();
        push(1'b0, 1'b1, '0, '0, '0, '0);
        @(negedge clk);
        chk("ovf_marker_level", fifo_level, 16);
        chk("ovf_marker_drop", drop_count, 4);
        step();
        collect(0, 200);
        compare_beats("ovf_drain");
        chk("ovf_swaps", swaps, 1);
        chk("ovf_swap_at", swap_at, 48);
        @(negedge clk);
        chk("ovf_front", front_buf_sel, 1);
        chk("ovf_end_level", fifo_level, 0);
        chk("ovf_end_busy", wb_busy, 0);
        chk("ovf_sticky", overflow, 1);
        step();

        // Reset while beat 1 is stalled, with one more pixel queued
        push(1'b1, 1'b0, 32'd2, 32'h5555_0000, 32'h5555_0001, 32'h5555_0002);
        push(1'b1, 1'b0, 32'd9, 32'h9999_0000, 32'h9999_0001, 32'h9999_0002);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rmb_beat0_addr", mem_addr, B0 + 32'd24);
        chk("rmb_beat0_valid", mem_valid, 1);
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rmb_beat1_data", mem_data, 32'h5555_0001);
        chk("rmb_beat1_level", fifo_level, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rmb_valid", mem_valid, 0);
        chk("rmb_level", fifo_level, 0);
        chk("rmb_front", front_buf_sel, 0);
        chk("rmb_drop", drop_count, 0);
        chk("rmb_overflow", overflow, 0);
        chk("rmb_busy", wb_busy, 0);
        step();
        push(1'b1, 1'b0, 32'd4, 32'h4444_0000, 32'h4444_0001, 32'h4444_0002);
        exp_pixel(B1, 32'd4, 32'h4444_0000, 32'h4444_0001, 32'h4444_0002);
        collect(0, 10);
        compare_beats("rmb_restart");

        // Randomized traffic against a transaction-level model of beats and flips
        m_front = 1'b0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = '0; pd = '0;
        for (int c = 0; c < 520; c++) begin
            mem_ready = ($urandom_range(0, 1) == 1);
            pixel_write_en = 1'b0;
            frame_done_in = 1'b0;
            if (c < 400 && c % 8 == 0) begin
                kind = $urandom_range(0, 9);
                if (kind == 0) begin
                    frame_done_in = 1'b1;
                    m_front = ~m_front;
                    ev = '{1'b1, '0, '0, 1'b0, m_front};
                    evq.push_back(ev);
                end else begin
                    ra = $urandom(); r0 = $urandom(); r1 = $urandom(); r2 = $urandom();
                    pixel_write_en = 1'b1;
                    frame_done_in = (kind == 1);
                    pixel_addr = ra; pixel_word0 = r0; pixel_word1 = r1; pixel_word2 = r2;
                    roff = (m_front ? B0 : B1) + ra * 32'd12;
                    ev = '{1'b0, roff, r0, 1'b0, m_front};          evq.push_back(ev);
                    ev = '{1'b0, roff + 32'd4, r1, 1'b0, m_front};  evq.push_back(ev);
                    ev = '{1'b0, roff + 32'd8, r2, 1'b1, m_front};  evq.push_back(ev);
                    if (kind == 1) begin
                        m_front = ~m_front;
                        ev = '{1'b1, '0, '0, 1'b0, m_front};
                        evq.push_back(ev);
                    end
                end
            end
            @(negedge clk);
            if (pv && !pr) begin
                chk("rnd_hold_valid", mem_valid, 1);
                chk("rnd_hold_addr", mem_addr, pa);
                chk("rnd_hold_data", mem_data, pd);
            end
            if (frame_swap) begin
                chk("rnd_swap_expected", (evq.size() > 0 && evq[0].sw) ? 1 : 0, 1);
                if (evq.size() > 0 && evq[0].sw) begin
                    chk("rnd_swap_front", front_buf_sel, evq[0].f);
                    void'(evq.pop_front());
                end
            end
            if (mem_valid && mem_ready) begin
                chk("rnd_beat_expected", (evq.size() > 0 && !evq[0].sw) ? 1 : 0, 1);
                if (evq.size() > 0 && !evq[0].sw) begin
                    chk("rnd_addr", mem_addr, evq[0].a);
                    chk("rnd_data", mem_data, evq[0].d);
                    chk("rnd_last", mem_last, evq[0].l);
                    void'(evq.pop_front());
                end
            end
            pv = mem_valid; pr = mem_ready; pa = mem_addr; pd = mem_data;
            step();
        end
        pixel_write_en = 1'b0;
        frame_done_in = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rnd_all_events_seen", evq.size(), 0);
        chk("rnd_no_drops", drop_count, 0);
        chk("rnd_final_front", front_buf_sel, m_front);
        chk("rnd_idle", wb_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time bound");
        $fatal(1, "timeout");
    end

endmodule
